// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and FSM state type for the fetch stage
package fetch_pkg;

    localparam int OPC_W = 7;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - IF/ID register control and contents bundle
interface fetch_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             load;
    logic             bubble;
    logic [PC_W-1:0]  pc_in;
    logic [INS_W-1:0] instr_in;
    logic             valid;
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;

    modport master (output load, bubble, pc_in, instr_in, input valid, pc, instr);
    modport slave  (input load, bubble, pc_in, instr_in, output valid, pc, instr);
endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load / bubble / hold controls
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input logic    clk,
    input logic    reset,
    fetch_if.slave ifid
);

    // bubble wins over load; neither asserted means hold
    always_ff @(posedge clk) begin
        if (reset || ifid.bubble) begin
            ifid.valid <= 1'b0;
            ifid.pc    <= '0;
            ifid.instr <= INS_W'(NOP);
        end else if (ifid.load) begin
            ifid.valid <= 1'b1;
            ifid.pc    <= ifid.pc_in;
            ifid.instr <= ifid.instr_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, next-PC selection and BOOT/RUN/HALT control (option: FETCH_MISALIGN_CHK_EN)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic [INS_W-1:0] imem_rdata_i,
    output logic             ifid_valid_o,
    output logic [PC_W-1:0]  ifid_pc_o,
    output logic [INS_W-1:0] ifid_instr_o,
    output logic [OPC_W-1:0] ifid_opcode_o,
    output logic             halted_o,
    output logic             misalign_o
);

    fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) ifid_bus ();

    ifid_reg #(.PC_W(PC_W), .INS_W(INS_W)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .ifid  (ifid_bus)
    );

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] redirect_tgt;

    assign pc_plus4 = pc_q + PC_W'(4);

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;
    logic misalign_set;
    logic misaligned;

    assign redirect_tgt = redirect_pc_i;
    assign misaligned   = |redirect_pc_i[1:0];
    assign misalign_o   = misalign_q;

    always_ff @(posedge clk) begin
        if (reset)
            misalign_q <= 1'b0;
        else if (misalign_set)
            misalign_q <= 1'b1;
    end
`else
    logic unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc_i[PC_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign misalign_o           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_bus.load   = 1'b0;
        ifid_bus.bubble = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_set    = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                ifid_bus.bubble = 1'b1;
                state_d         = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    ifid_bus.bubble = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
                    if (misaligned) begin
                        misalign_set = 1'b1;
                        state_d      = HALT;
                    end else begin
                        pc_d = redirect_tgt;
                    end
`else
                    pc_d = redirect_tgt;
`endif
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (flush_i) begin
                    ifid_bus.bubble = 1'b1;
                    pc_d            = pc_plus4;
                end else begin
                    ifid_bus.load = 1'b1;
                    pc_d          = pc_plus4;
                    if (imem_rdata_i == INS_W'(EBREAK))
                        state_d = HALT;
                end
            end
            HALT: begin
                ifid_bus.bubble = 1'b1;
            end
            default: begin
                ifid_bus.bubble = 1'b1;
                state_d         = BOOT;
            end
        endcase
    end

    assign ifid_bus.pc_in    = pc_q;
    assign ifid_bus.instr_in = imem_rdata_i;

    assign imem_addr_o   = pc_q;
    assign ifid_valid_o  = ifid_bus.valid;
    assign ifid_pc_o     = ifid_bus.pc;
    assign ifid_instr_o  = ifid_bus.instr;
    assign ifid_opcode_o = ifid_bus.instr[OPC_W-1:0];
    assign halted_o      = (state_q == HALT);

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter PC_W, default 9, meaning PC/instruction-address width in bits.
REQ-002 SHALL provide parameter INS_W, default 32, meaning instruction width in bits.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port stall_i  input  1  hold PC and IF/ID contents.
REQ-006 SHALL provide port flush_i  input  1  load bubble into IF/ID.
REQ-007 SHALL provide port redirect_i  input  1  taken branch/jal/jalr, load redirect_pc_i into PC.
REQ-008 SHALL provide port redirect_pc_i  input  PC_W  redirect target address.
REQ-009 SHALL provide port imem_addr_o  output  PC_W  current PC to instruction memory, driven directly from PC register.
REQ-010 SHALL provide port imem_rdata_i  input  INS_W  instruction word, combinational read of imem_addr_o.
REQ-011 SHALL provide port ifid_valid_o  output  1  IF/ID holds real instruction.
REQ-012 SHALL provide port ifid_pc_o  output  PC_W  PC of IF/ID instruction.
REQ-013 SHALL provide port ifid_instr_o  output  INS_W  IF/ID instruction word.
REQ-014 SHALL provide port ifid_opcode_o  output  7  ifid_instr_o[6:0], feeds decode controller.
REQ-015 SHALL provide port halted_o  output  1  high in HALT state.
REQ-016 SHALL provide port misalign_o  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT.
REQ-018 BOOT: one cycle after reset; PC holds 0, IF/ID holds bubble; unconditional transition to RUN.
REQ-019 RUN per-cycle priority: redirect_i > stall_i > flush_i > normal fetch.
REQ-020 Normal fetch: IF/ID <= {valid=1, pc=PC, instr=imem_rdata_i}; PC <= PC+4, wrapping modulo 2^PC_W.
REQ-021 redirect_i in RUN: PC <= redirect_pc_i; IF/ID <= bubble; applies regardless of stall_i/flush_i.
REQ-022 stall_i without redirect_i: PC and IF/ID unchanged, even if flush_i also high.
REQ-023 flush_i alone: IF/ID <= bubble; PC <= PC+4.
REQ-024 Bubble: valid=0, instr=NOP (0x00000013), pc=0.
REQ-025 RUN->HALT when a normal fetch captures EBREAK (0x00100073); EBREAK itself enters IF/ID with valid=1.
REQ-026 HALT: PC held; IF/ID <= bubble each cycle; redirect_i, stall_i, flush_i ignored; exit only by reset.
REQ-027 Fetch-to-IF/ID latency SHALL be exactly one cycle; ifid_opcode_o SHALL always equal ifid_instr_o[6:0].

Reset
REQ-028 reset high at a clock edge SHALL set PC=0, IF/ID=bubble, state=BOOT, halted_o=0, misalign_o=0, overriding all other inputs, including mid-stall or in HALT.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHK_EN defined: accepted redirect with redirect_pc_i[1:0]!=0 SHALL set misalign_o (sticky until reset), load bubble, hold PC, enter HALT.
REQ-030 Macro undefined: redirect target SHALL be loaded with bits [1:0] forced to 00; misalign_o SHALL be tied 0.

Structure
REQ-031 Package fetch_pkg SHALL hold NOP and EBREAK constants, opcode width (7), and FSM state enum.
REQ-032 IF/ID register SHALL be sub-module ifid_reg (valid/pc/instr, load/bubble/hold controls); PC, next-PC logic and FSM stay in fetch_stage.

Verification
REQ-033 Reset released, imem returns addr-encoded words -> cycle 1 BOOT (valid=0), cycle 2 ifid_pc_o=0x000 valid=1, cycle 3 ifid_pc_o=0x004.
REQ-034 stall_i and flush_i high together for 2 cycles at PC=0x010 -> PC and IF/ID unchanged; release -> ifid_pc_o=0x010 next cycle.
REQ-035 redirect_i=1, stall_i=1, redirect_pc_i=0x040 -> next cycle IF/ID bubble, imem_addr_o=0x040; following cycle ifid_pc_o=0x040.
REQ-036 PC=0x1FC (PC_W=9) normal fetch -> next PC=0x000.
REQ-037 imem returns 0x00100073 at 0x008 -> EBREAK in IF/ID valid=1, halted_o=1 next cycle, PC stays 0x00C, redirect ignored; reset -> PC=0, halted_o=0.
REQ-038 With FETCH_MISALIGN_CHK_EN, redirect_pc_i=0x022 -> misalign_o=1, halted_o=1; without macro -> PC=0x020, misalign_o=0.
